// File: rtl/sc_io_seg_display.sv
// ---------------------------------------------------------------------------
// sc_io_seg_display
//
// Purpose:
//   Shows the two CPU output-port values (out_port1 / out_port2) in decimal
//   on six 7-segment digits, three per channel. A single sequential
//   shift-and-add-3 converter is time-shared between the two channels.
//   Each channel watches its input for changes and queues a conversion.
//   When both channels are waiting they are served alternately.
//
// Ports:
//   clock      in   1   system clock, rising edge
//   resetn     in   1   asynchronous active-low reset
//   in_a       in  32   channel A value (out_port1)
//   in_b       in  32   channel B value (out_port2)
//   hex5..3    out  7   channel A hundreds/tens/units, active-low gfedcba
//   hex2..0    out  7   channel B hundreds/tens/units, active-low gfedcba
//   busy       out  1   high in LOAD, SHIFT and WRITE
//   done       out  1   one-cycle pulse in the cycle a channel's hex outputs
//                       take their new value
//   fsm_state  out  2   current converter state, for observation
//
// Handshake: there is no valid/ready pair. Each input is level-sampled.
// A difference from the last converted value raises that channel's pending
// flag. The conversion itself reads the input once, in LOAD, and only that
// snapshot reaches the display.
// ---------------------------------------------------------------------------
module sc_io_seg_display #(
    parameter int          BLANK_LZ = 1,
    parameter int unsigned MAX_VAL  = 999
) (
    input  logic        clock,
    input  logic        resetn,
    input  logic [31:0] in_a,
    input  logic [31:0] in_b,
    output logic [6:0]  hex5,
    output logic [6:0]  hex4,
    output logic [6:0]  hex3,
    output logic [6:0]  hex2,
    output logic [6:0]  hex1,
    output logic [6:0]  hex0,
    output logic        busy,
    output logic        done,
    output logic [1:0]  fsm_state
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_LOAD  = 2'd1;
    localparam logic [1:0] S_SHIFT = 2'd2;
    localparam logic [1:0] S_WRITE = 2'd3;

    localparam logic [6:0]  SEG_DASH  = 7'b0111111;
    localparam logic [6:0]  SEG_BLANK = 7'b1111111;
    localparam logic [31:0] MAX_W     = 32'(MAX_VAL);
    localparam logic [3:0]  LAST_CNT  = 4'd9;

    logic [1:0]  state;
    logic        sel;        // channel being converted: 0 = A, 1 = B
    logic        last_sel;   // channel served most recently
    logic        pend_a;
    logic        pend_b;
    logic [31:0] last_a;
    logic [31:0] last_b;
    logic        ovf;
    logic [21:0] shreg;      // {bcd[11:0], bin[9:0]}
    logic [3:0]  cnt;

    logic [31:0] snap;
    logic        snap_ovf;
    logic [3:0]  nib0;
    logic [3:0]  nib1;
    logic [3:0]  nib2;
    logic [21:0] shifted;
    logic        unused_nib2_msb;
    logic [3:0]  bcd_h;
    logic [3:0]  bcd_t;
    logic [3:0]  bcd_u;
    logic [6:0]  dig_h;
    logic [6:0]  dig_t;
    logic [6:0]  dig_u;
    logic        pick_a;

    // Active-low gfedcba segment code for one BCD digit.
    function automatic logic [6:0] seg_code(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'b1000000;
            4'd1:    s = 7'b1111001;
            4'd2:    s = 7'b0100100;
            4'd3:    s = 7'b0110000;
            4'd4:    s = 7'b0011001;
            4'd5:    s = 7'b0010010;
            4'd6:    s = 7'b0000010;
            4'd7:    s = 7'b1111000;
            4'd8:    s = 7'b0000000;
            4'd9:    s = 7'b0010000;
            default: s = SEG_BLANK;
        endcase
        return s;
    endfunction

    assign busy      = (state != S_IDLE);
    assign fsm_state = state;

    // The selected input is read directly in LOAD. The overflow compare
    // uses all 32 bits. Only bits [9:0] ever enter the shifter.
    assign snap     = sel ? in_b : in_a;
    assign snap_ovf = (snap > MAX_W);

    // A channel waiting alone is served at once. When both are waiting, the
    // one not served last goes first. last_sel resets to B, so A goes first
    // after reset.
    assign pick_a = pend_a && (!pend_b || last_sel);

    // One shift-and-add-3 step: correct every BCD nibble that is 5 or
    // more, then shift the whole {bcd, bin} register left by one. The
    // hundreds nibble is at most 4 before the final shift for values up to
    // 999, so its carry-out bit can be dropped.
    always_comb begin
        nib0 = shreg[13:10];
        nib1 = shreg[17:14];
        nib2 = shreg[21:18];
        if (nib0 >= 4'd5) nib0 = nib0 + 4'd3;
        if (nib1 >= 4'd5) nib1 = nib1 + 4'd3;
        if (nib2 >= 4'd5) nib2 = nib2 + 4'd3;
        shifted = {nib2[2:0], nib1, nib0, shreg[9:0], 1'b0};
    end

    assign unused_nib2_msb = nib2[3];

    assign bcd_h = shreg[21:18];
    assign bcd_t = shreg[17:14];
    assign bcd_u = shreg[13:10];

    // Digit codes for the WRITE cycle. Overflow overrides everything.
    // Leading-zero blanking never blanks the units digit, and it blanks
    // the tens digit only when the hundreds digit is blank as well.
    always_comb begin
        dig_h = seg_code(bcd_h);
        dig_t = seg_code(bcd_t);
        dig_u = seg_code(bcd_u);
        if (BLANK_LZ != 0) begin
            if (bcd_h == 4'd0) dig_h = SEG_BLANK;
            if ((bcd_h == 4'd0) && (bcd_t == 4'd0)) dig_t = SEG_BLANK;
        end
        if (ovf) begin
            dig_h = SEG_DASH;
            dig_t = SEG_DASH;
            dig_u = SEG_DASH;
        end
    end

    // Change detection runs every cycle, including during a conversion.
    // In LOAD the served channel records its snapshot and clears its flag.
    // The flag rises again only if a later input differs from that snapshot.
    // Both flags reset high, so both channels convert after reset.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            last_a <= 32'd0;
            last_b <= 32'd0;
            pend_a <= 1'b1;
            pend_b <= 1'b1;
        end else begin
            if ((state == S_LOAD) && !sel) begin
                last_a <= in_a;
                pend_a <= 1'b0;
            end else if (in_a != last_a) begin
                pend_a <= 1'b1;
            end

            if ((state == S_LOAD) && sel) begin
                last_b <= in_b;
                pend_b <= 1'b0;
            end else if (in_b != last_b) begin
                pend_b <= 1'b1;
            end
        end
    end

    // Converter FSM and output registers.
    // The normal path is IDLE, LOAD, 10 x SHIFT, then WRITE.
    // The overflow path goes from LOAD straight to WRITE.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state    <= S_IDLE;
            sel      <= 1'b0;
            last_sel <= 1'b1;
            ovf      <= 1'b0;
            shreg    <= 22'd0;
            cnt      <= 4'd0;
            done     <= 1'b0;
            hex5     <= SEG_BLANK;
            hex4     <= SEG_BLANK;
            hex3     <= SEG_BLANK;
            hex2     <= SEG_BLANK;
            hex1     <= SEG_BLANK;
            hex0     <= SEG_BLANK;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (pick_a) begin
                        sel   <= 1'b0;
                        state <= S_LOAD;
                    end else if (pend_b) begin
                        sel   <= 1'b1;
                        state <= S_LOAD;
                    end
                end

                S_LOAD: begin
                    last_sel <= sel;
                    if (snap_ovf) begin
                        ovf   <= 1'b1;
                        state <= S_WRITE;
                    end else begin
                        ovf   <= 1'b0;
                        shreg <= {12'd0, snap[9:0]};
                        cnt   <= 4'd0;
                        state <= S_SHIFT;
                    end
                end

                S_SHIFT: begin
                    shreg <= shifted;
                    cnt   <= cnt + 4'd1;
                    if (cnt == LAST_CNT) begin
                        state <= S_WRITE;
                    end
                end

                S_WRITE: begin
                    // Only the served channel's digits change.
                    // The other channel's digits keep their value.
                    if (!sel) begin
                        hex5 <= dig_h;
                        hex4 <= dig_t;
                        hex3 <= dig_u;
                    end else begin
                        hex2 <= dig_h;
                        hex1 <= dig_t;
                        hex0 <= dig_u;
                    end
                    done  <= 1'b1;
                    state <= S_IDLE;
                end

                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sc_io_seg_display.sv
`timescale 1ns/1ps
module tb_sc_io_seg_display;

    // ---------------- clock / reset ----------------
    logic        clock  = 1'b0;
    logic        resetn = 1'b1;
    logic [31:0] in_a   = 32'd0;
    logic [31:0] in_b   = 32'd0;

    logic [6:0] hex5, hex4, hex3, hex2, hex1, hex0;
    logic       busy, done;
    logic [1:0] fsm_state;
    logic [6:0] n5, n4, n3, n2, n1, n0;
    logic       n_busy, n_done;
    logic [1:0] n_state;

    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    sc_io_seg_display #(.BLANK_LZ(1), .MAX_VAL(999)) dut (
        .clock(clock), .resetn(resetn), .in_a(in_a), .in_b(in_b),
        .hex5(hex5), .hex4(hex4), .hex3(hex3),
        .hex2(hex2), .hex1(hex1), .hex0(hex0),
        .busy(busy), .done(done), .fsm_state(fsm_state)
    );

    sc_io_seg_display #(.BLANK_LZ(0), .MAX_VAL(999)) dut_nb (
        .clock(clock), .resetn(resetn), .in_a(in_a), .in_b(in_b),
        .hex5(n5), .hex4(n4), .hex3(n3),
        .hex2(n2), .hex1(n1), .hex0(n0),
        .busy(n_busy), .done(n_done), .fsm_state(n_state)
    );

    // ---------------- checking ----------------
    int n_tests = 0;
    int n_fail  = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    localparam logic [6:0]  BLANK = 7'b1111111;
    localparam logic [6:0]  DASH  = 7'b0111111;
    localparam logic [41:0] ALL_BLANK = {6{7'b1111111}};

    function automatic logic [6:0] seg7(input int d);
        case (d)
            0: return 7'b1000000;
            1: return 7'b1111001;
            2: return 7'b0100100;
            3: return 7'b0110000;
            4: return 7'b0011001;
            5: return 7'b0010010;
            6: return 7'b0000010;
            7: return 7'b1111000;
            8: return 7'b0000000;
            9: return 7'b0010000;
            default: return BLANK;
        endcase
    endfunction

    function automatic logic [20:0] show(input logic [31:0] v, input bit lz);
        int h, t, u;
        logic [6:0] sh, st, su;
        if (v > 32'd999) return {DASH, DASH, DASH};
        h  = int'(v) / 100;
        t  = (int'(v) / 10) % 10;
        u  = int'(v) % 10;
        sh = (lz && h == 0) ? BLANK : seg7(h);
        st = (lz && h == 0 && t == 0) ? BLANK : seg7(t);
        su = seg7(u);
        return {sh, st, su};
    endfunction

    // ---------------- scoreboard ----------------
    // Each entry is {channel, digits with blanking, digits without blanking}.
    logic [42:0] exp_q[$];
    logic [42:0] mon_e;
    logic [41:0] mdl    = ALL_BLANK;
    logic [41:0] mdl_nb = ALL_BLANK;
    int last_done_a = 0;
    int last_done_b = 0;

    task automatic expect_conv(input bit ch, input logic [31:0] v);
        exp_q.push_back({ch, show(v, 1'b1), show(v, 1'b0)});
    endtask

    // In free mode the bench does not predict the conversion order.
    // Instead, each displayed value must be one the channel actually held.
    bit          free_mode = 1'b0;
    logic [31:0] pre_a, pre_b;
    logic [20:0] prev_a, prev_b;
    int          chg_a = 0;
    int          chg_b = 0;
    bit          ok_a, ok_b;

    function automatic logic [31:0] fa(input int p);
        return 32'(100 + p);
    endfunction

    function automatic logic [31:0] fb(input int p);
        return (p % 2 == 1) ? 32'(5000 + p) : 32'(800 + p);
    endfunction

    always @(negedge clock) begin
        if (resetn) begin
            if (done) begin
                if (free_mode) begin
                    ok_a = ({hex5, hex4, hex3} == show(pre_a, 1'b1));
                    ok_b = ({hex2, hex1, hex0} == show(pre_b, 1'b1));
                    for (int p = 0; p < 8; p++) begin
                        if ({hex5, hex4, hex3} == show(fa(p), 1'b1)) ok_a = 1'b1;
                        if ({hex2, hex1, hex0} == show(fb(p), 1'b1)) ok_b = 1'b1;
                    end
                    check_eq("toggle_a_held", 64'(ok_a), 64'd1);
                    check_eq("toggle_b_held", 64'(ok_b), 64'd1);
                    if ({hex5, hex4, hex3} != prev_a) chg_a++;
                    if ({hex2, hex1, hex0} != prev_b) chg_b++;
                    prev_a = {hex5, hex4, hex3};
                    prev_b = {hex2, hex1, hex0};
                end else if (exp_q.size() == 0) begin
                    check_eq("unexpected_done", 64'd1, 64'd0);
                end else begin
                    mon_e = exp_q.pop_front();
                    if (!mon_e[42]) begin
                        mdl[41:21]    = mon_e[41:21];
                        mdl_nb[41:21] = mon_e[20:0];
                        last_done_a   = cyc;
                    end else begin
                        mdl[20:0]     = mon_e[41:21];
                        mdl_nb[20:0]  = mon_e[20:0];
                        last_done_b   = cyc;
                    end
                end
            end
            // Outputs must equal the model on every cycle. Between updates
            // this checks that the digits hold their value.
            if (!free_mode) begin
                check_eq("hex_lz", {hex5, hex4, hex3, hex2, hex1, hex0}, mdl);
                check_eq("hex_nolz", {n5, n4, n3, n2, n1, n0}, mdl_nb);
            end
        end
    end

    // ---------------- driver tasks ----------------
    // Returns at posedge+1 once the queue is empty and busy has been low
    // for two consecutive samples.
    task automatic wait_idle(input int budget);
        int quiet;
        int n;
        quiet = 0;
        n = 0;
        while (quiet < 2) begin
            @(negedge clock);
            if (!busy && exp_q.size() == 0) quiet++;
            else quiet = 0;
            n++;
            if (n > budget) begin
                check_eq("timeout", 64'd1, 64'd0);
                quiet = 2;
            end
        end
        @(posedge clock);
        #1;
    endtask

    // Latency counted from the edge before the input change. The pending
    // flag rises one edge after the change, then 13 more edges follow
    // (3 on overflow).
    task automatic run_one(input bit ch, input logic [31:0] v, input int lat, input string tag);
        int c0;
        c0 = cyc;
        if (ch) in_b = v;
        else    in_a = v;
        expect_conv(ch, v);
        wait_idle(100);
        check_eq(tag, 64'(ch ? (last_done_b - c0) : (last_done_a - c0)), 64'(lat));
    endtask

    task automatic check_reset_outputs(input string tag);
        check_eq({tag, "_hex"},    {hex5, hex4, hex3, hex2, hex1, hex0}, ALL_BLANK);
        check_eq({tag, "_hex_nb"}, {n5, n4, n3, n2, n1, n0},             ALL_BLANK);
        check_eq({tag, "_busy"},   64'({busy, n_busy}), 64'd0);
        check_eq({tag, "_done"},   64'({done, n_done}), 64'd0);
    endtask

    // ---------------- stimulus ----------------
    bit          tch[9];
    logic [31:0] tv[9];
    int          tl[9];

    initial begin
        int c0;

        tch = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        tv  = '{32'd0, 32'd1000, 32'hFFFF_FFFF, 32'd999, 32'd7, 32'd50,
                32'd100, 32'h0001_0005, 32'd1023};
        tl  = '{14, 4, 4, 14, 14, 14, 14, 4, 4};

        // Reset with both values already present.
        #1 resetn = 1'b0;
        in_a = 32'd123;
        in_b = 32'd45;
        repeat (3) @(posedge clock);
        @(negedge clock);
        check_reset_outputs("reset");
        @(posedge clock);
        #1;
        resetn = 1'b1;
        c0 = cyc;
        expect_conv(1'b0, 32'd123);
        expect_conv(1'b1, 32'd45);
        wait_idle(100);
        check_eq("reset_lat_a", 64'(last_done_a - c0), 64'd13);
        check_eq("reset_gap_b", 64'(last_done_b - last_done_a), 64'd13);

        // Boundary values: zero, overflow, 999, blanking cases.
        for (int i = 0; i < 9; i++) begin
            run_one(tch[i], tv[i], tl[i], $sformatf("lat_%0d", i));
        end

        // Input changes 5 -> 6 during the fourth SHIFT cycle.
        c0 = cyc;
        in_a = 32'd5;
        expect_conv(1'b0, 32'd5);
        expect_conv(1'b0, 32'd6);
        for (int k = 1; k <= 27; k++) begin
            @(posedge clock);
            #1;
            if (k == 6) in_a = 32'd6;
            @(negedge clock);
            if (k >= 2) check_eq($sformatf("busy_mid_%0d", k), 64'(busy), 64'(k != 14 && k != 27));
        end
        wait_idle(100);
        check_eq("mid_second_done", 64'(last_done_a - c0), 64'd27);

        // Both inputs change every 13 cycles, always to values not held
        // before.
        pre_a  = in_a;
        pre_b  = in_b;
        prev_a = {hex5, hex4, hex3};
        prev_b = {hex2, hex1, hex0};
        free_mode = 1'b1;
        for (int p = 0; p < 8; p++) begin
            in_a = fa(p);
            in_b = fb(p);
            repeat (13) @(posedge clock);
            #1;
        end
        wait_idle(200);
        check_eq("starve_a", 64'(chg_a >= 3), 64'd1);
        check_eq("starve_b", 64'(chg_b >= 3), 64'd1);
        mdl    = {show(in_a, 1'b1), show(in_b, 1'b1)};
        mdl_nb = {show(in_a, 1'b0), show(in_b, 1'b0)};
        free_mode = 1'b0;
        @(negedge clock);
        @(posedge clock);
        #1;

        // Reset asserted in the middle of SHIFT.
        in_a = 32'd321;
        in_b = 32'd45;
        repeat (6) @(posedge clock);
        #1;
        resetn = 1'b0;
        #1;
        check_reset_outputs("async_reset");
        exp_q.delete();
        mdl    = ALL_BLANK;
        mdl_nb = ALL_BLANK;
        @(posedge clock);
        #1;
        resetn = 1'b1;
        c0 = cyc;
        expect_conv(1'b0, 32'd321);
        expect_conv(1'b1, 32'd45);
        wait_idle(100);
        check_eq("rereset_lat_a", 64'(last_done_a - c0), 64'd13);
        check_eq("rereset_gap_b", 64'(last_done_b - last_done_a), 64'd13);

        repeat (5) @(posedge clock);
        check_eq("queue_empty", 64'(exp_q.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired at t=%0t", $time);
        $fatal(1, "watchdog");
    end

endmodule
